// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, port indices and response-slot record for the data-memory arbiter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 12
`endif

package dmem_arbiter_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  is_read;
  } rsp_slot_t;

  // An all-zero byte-enable mask is a read.
  function automatic logic is_read_op(input logic [BYTE_LANES-1:0] we);
    return (we == '0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both requesters plus the single-port memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = `DATA_MEM_ADDR_WIDTH,
  parameter int XLEN_W = `XLEN
);
  localparam int WE_W = dmem_arbiter_pkg::BYTE_LANES;

  logic              p0_req_valid;
  logic              p0_req_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [XLEN_W-1:0] p0_wdata;
  logic [WE_W-1:0]   p0_we;
  logic              p0_rsp_valid;
  logic [XLEN_W-1:0] p0_rdata;

  logic              p1_req_valid;
  logic              p1_req_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [XLEN_W-1:0] p1_wdata;
  logic [WE_W-1:0]   p1_we;
  logic              p1_rsp_valid;
  logic [XLEN_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_adra;
  logic [XLEN_W-1:0] mem_dina;
  logic [WE_W-1:0]   mem_wea;
  logic [XLEN_W-1:0] mem_douta;

  modport slave (
    input  p0_req_valid, p0_addr, p0_wdata, p0_we,
    output p0_req_ready, p0_rsp_valid, p0_rdata,
    input  p1_req_valid, p1_addr, p1_wdata, p1_we,
    output p1_req_ready, p1_rsp_valid, p1_rdata,
    output mem_adra, mem_dina, mem_wea,
    input  mem_douta
  );

  modport master (
    output p0_req_valid, p0_addr, p0_wdata, p0_we,
    input  p0_req_ready, p0_rsp_valid, p0_rdata,
    output p1_req_valid, p1_addr, p1_wdata, p1_we,
    input  p1_req_ready, p1_rsp_valid, p1_rdata,
    input  mem_adra, mem_dina, mem_wea,
    output mem_douta
  );

endinterface

// File: rtl/dmem_arb_grant.sv
// Two-port grant: fixed p0 priority with p1 starvation override, or round-robin when
// DMEM_ARB_RR_EN is defined. Grants are combinational; nothing is granted on the first edge after reset.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic armed;
  logic pick1;
  logic contended;

  assign contended = req0 && req1;

  // Holds off arbitration for one edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

`ifdef DMEM_ARB_RR_EN
  port_e ptr;

  assign pick1 = (ptr == PORT_DMA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= PORT_CPU;
    end else if (armed && contended) begin
      ptr <= (ptr == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end
  end
`else
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve;

  assign pick1 = (starve == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (!req1 || gnt1) begin
      starve <= '0;
    end else if (armed && (starve != CNT_MAX)) begin
      starve <= starve + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (armed) begin
      if (contended) begin
        gnt1 = pick1;
        gnt0 = !pick1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CPU (p0) and loader/DMA (p1); response one cycle
// after acceptance, full throughput. Arbitration mode selected by DMEM_ARB_RR_EN (see dmem_arb_grant).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = `DATA_MEM_ADDR_WIDTH,
  parameter int XLEN_W     = `XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_W-1:0]     adr_sel;
  logic [XLEN_W-1:0]     din_sel;
  logic [BYTE_LANES-1:0] we_sel;
  rsp_slot_t             slot;
  logic                  rsp0;
  logic                  rsp1;

  dmem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (bus.p0_req_valid),
    .req1    (bus.p1_req_valid),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign bus.p0_req_ready = gnt0;
  assign bus.p1_req_ready = gnt1;

  always_comb begin
    adr_sel = '0;
    din_sel = '0;
    we_sel  = '0;
    if (gnt0) begin
      adr_sel = bus.p0_addr;
      din_sel = bus.p0_wdata;
      we_sel  = bus.p0_we;
    end else if (gnt1) begin
      adr_sel = bus.p1_addr;
      din_sel = bus.p1_wdata;
      we_sel  = bus.p1_we;
    end
  end

  assign bus.mem_adra = adr_sel;
  assign bus.mem_dina = din_sel;
  assign bus.mem_wea  = we_sel;

  // The memory read lands one cycle later; the slot remembers whose it is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
    end else begin
      slot.valid   <= gnt0 || gnt1;
      slot.owner   <= gnt1 ? PORT_DMA : PORT_CPU;
      slot.is_read <= is_read_op(we_sel);
    end
  end

  assign rsp0 = slot.valid && (slot.owner == PORT_CPU);
  assign rsp1 = slot.valid && (slot.owner == PORT_DMA);

  assign bus.p0_rsp_valid = rsp0;
  assign bus.p1_rsp_valid = rsp1;
  assign bus.p0_rdata     = (rsp0 && slot.is_read) ? bus.mem_douta : '0;
  assign bus.p1_rdata     = (rsp1 && slot.is_read) ? bus.mem_douta : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against a transaction-level model with a word-array memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW    = `DATA_MEM_ADDR_WIDTH;
  localparam int XW    = `XLEN;
  localparam int SMAX  = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [XW-1:0] wdata;
    logic [3:0]    we;
  } req_t;

  typedef struct {
    bit            valid;
    bit            owner;
    bit            is_read;
    logic [XW-1:0] data;
  } exp_rsp_t;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic mem_clear = 1'b1;
  int   checks    = 0;
  int   errors    = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .XLEN_W(XW)) bus();

  dmem_arbiter #(.ADDR_W(AW), .XLEN_W(XW), .STARVE_MAX(SMAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory with byte enables and a registered read.
  logic [XW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wea[b]) ram[bus.mem_adra][8*b +: 8] <= bus.mem_dina[8*b +: 8];
    end
    bus.mem_douta <= ram[bus.mem_adra];
  end

  // Reference model state.
  logic [XW-1:0] ref_mem [DEPTH];
  req_t          q0[$];
  req_t          q1[$];
  exp_rsp_t      pend;
  int            era;
  int            p1_wait;
  bit            last_win1;
  int            glog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input int addr, input logic [XW-1:0] d, input logic [3:0] we);
    req_t r;
    r.addr  = AW'(addr);
    r.wdata = d;
    r.we    = we;
    return r;
  endfunction

  function automatic logic [XW-1:0] merge(input logic [XW-1:0] old, input logic [XW-1:0] d,
                                          input logic [3:0] we);
    logic [XW-1:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  task automatic model_reset();
    pend.valid   = 0;
    pend.owner   = 0;
    pend.is_read = 0;
    pend.data    = '0;
    p1_wait      = 0;
    last_win1    = 1;
    era          = 0;
  endtask

  // One clock: present queue heads, check mid-cycle, advance model, cross the edge.
  task automatic step();
    req_t             r0, r1, rs;
    bit               v0, v1, g0, g1, armed;
    logic [XW-1:0]    rd0, rd1;
    logic [AW+XW+3:0] exp_bus;
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    r0 = v0 ? q0[0] : mk(0, '0, 4'h0);
    r1 = v1 ? q1[0] : mk(0, '0, 4'h0);
    bus.p0_req_valid = v0; bus.p0_addr = r0.addr; bus.p0_wdata = r0.wdata; bus.p0_we = r0.we;
    bus.p1_req_valid = v1; bus.p1_addr = r1.addr; bus.p1_wdata = r1.wdata; bus.p1_we = r1.we;
    @(negedge clk);
    armed = reset_n && (era > 0);
    g0 = 0;
    g1 = 0;
    if (armed) begin
      if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
        g1 = !last_win1;
`else
        g1 = (p1_wait >= SMAX);
`endif
        g0 = !g1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    exp_bus = '0;
    if (g0)      exp_bus = {r0.addr, r0.wdata, r0.we};
    else if (g1) exp_bus = {r1.addr, r1.wdata, r1.we};
    rd0 = (pend.valid && !pend.owner && pend.is_read) ? pend.data : '0;
    rd1 = (pend.valid &&  pend.owner && pend.is_read) ? pend.data : '0;
    chk("p0_req_ready", 64'(bus.p0_req_ready), 64'(g0));
    chk("p1_req_ready", 64'(bus.p1_req_ready), 64'(g1));
    chk("mem_bus", 64'({bus.mem_adra, bus.mem_dina, bus.mem_wea}), 64'(exp_bus));
    chk("p0_rsp_valid", 64'(bus.p0_rsp_valid), 64'(pend.valid && !pend.owner));
    chk("p1_rsp_valid", 64'(bus.p1_rsp_valid), 64'(pend.valid && pend.owner));
    chk("p0_rdata", 64'(bus.p0_rdata), 64'(rd0));
    chk("p1_rdata", 64'(bus.p1_rdata), 64'(rd1));
    pend.valid = g0 || g1;
    pend.owner = g1;
    if (g0 || g1) begin
      rs = g1 ? r1 : r0;
      pend.is_read = (rs.we == 4'h0);
      pend.data    = ref_mem[rs.addr];
      if (!pend.is_read) ref_mem[rs.addr] = merge(ref_mem[rs.addr], rs.wdata, rs.we);
    end
    if (g0) void'(q0.pop_front());
    if (g1) void'(q1.pop_front());
    if (armed && v0 && v1) last_win1 = g1;
    if (!v1 || g1)                    p1_wait = 0;
    else if (armed && p1_wait < SMAX) p1_wait++;
    glog.push_back(g1 ? 1 : (g0 ? 0 : -1));
    @(posedge clk);
    if (reset_n) era++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_budget", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic reset_pulse(input int cycles);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) step();
    reset_n = 1'b1;
  endtask

  initial begin
    int s;
    model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset with a request already waiting: nothing may be granted.
    q0.push_back(mk('h08, 32'h0, 4'h0));
    for (int i = 0; i < 3; i++) step();
    mem_clear = 1'b0;
    reset_n   = 1'b1;
    s = glog.size();
    drain(10);
    chk("first_edge_idle", 64'(glog[s]), 64'(-1));
    step();

    // Write then read back the same address on the next cycle.
    q0.push_back(mk('h10, 32'hDEADBEEF, 4'hF));
    q0.push_back(mk('h10, 32'h0, 4'h0));
    drain(10);
    chk("raw_rdata", 64'(bus.p0_rdata), 64'h0000_0000_DEAD_BEEF);
    step();

    // Byte-lane write merges into an existing word.
    q0.push_back(mk('h20, 32'h11223344, 4'hF));
    q0.push_back(mk('h20, 32'h0000AB00, 4'b0010));
    q0.push_back(mk('h20, 32'h0, 4'h0));
    drain(10);
    chk("byte_merge", 64'(bus.p0_rdata), 64'h0000_0000_1122_AB44);
    step();

    // p1 alone streams eight reads back to back.
    for (int i = 0; i < 8; i++) q0.push_back(mk('h40 + i, 32'hA5000000 + XW'(i * 'h111), 4'hF));
    drain(20);
    step();
    s = glog.size();
    for (int i = 0; i < 8; i++) q1.push_back(mk('h40 + i, 32'h0, 4'h0));
    drain(20);
    step();
    for (int i = 0; i < 8; i++) chk("p1_burst_gnt", 64'(glog[s + i]), 64'd1);

    // Continuous contention from a clean arbitration state.
    reset_pulse(2);
    for (int i = 0; i < 25; i++) begin
      q0.push_back(mk('h40 + (i % 8), 32'h0, 4'h0));
      q1.push_back(mk('h40 + ((i + 3) % 8), 32'h0, 4'h0));
    end
    step();
    s = glog.size();
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 20; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk("contend_pattern", 64'(glog[s + i]), 64'(i % 2));
`else
      chk("contend_pattern", 64'(glog[s + i]), 64'((i % 5) == 4));
`endif
    end
    drain(40);
    step();

    // Reset lands while a p1 read response is pending.
    q1.push_back(mk('h41, 32'h0, 4'h0));
    drain(10);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_p1_rsp_valid", 64'(bus.p1_rsp_valid), 64'd0);
    chk("rst_outputs", 64'({bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.mem_wea}), 64'd0);
    chk("rst_rdata", 64'({bus.p0_rdata, bus.p1_rdata}), 64'd0);
    q1.push_back(mk('h42, 32'h0, 4'h0));
    step();
    step();
    reset_n = 1'b1;
    s = glog.size();
    step();
    step();
    chk("post_rst_edge1", 64'(glog[s]), 64'(-1));
    chk("post_rst_edge2", 64'(glog[s + 1]), 64'd1);
    step();

    // Random traffic over a small address window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 99) < 60)
        q0.push_back(mk('h80 + $urandom_range(0, 7), XW'($urandom),
                        $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0));
      if (q1.size() == 0 && $urandom_range(0, 99) < 60)
        q1.push_back(mk('h80 + $urandom_range(0, 7), XW'($urandom),
                        $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0));
      step();
    end
    drain(20);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default `DATA_MEM_ADDR_WIDTH, meaning word-address width of the data memory.
REQ-002 SHALL have parameter XLEN_W, default `XLEN, meaning data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles port 1 may be denied while requesting.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports p0_req_valid, input, 1; p0_req_ready, output, 1; p0_addr, input, ADDR_W; p0_wdata, input, XLEN_W; p0_we, input, 4 (byte enables; 0 means read): the CPU port.
REQ-007 SHALL have ports p0_rsp_valid, output, 1; p0_rdata, output, XLEN_W: the CPU response.
REQ-008 SHALL have ports p1_req_valid, p1_req_ready, p1_addr, p1_wdata, p1_we, p1_rsp_valid and p1_rdata, with the same widths and directions as port 0: the loader/DMA port.
REQ-009 SHALL have ports mem_adra, output, ADDR_W; mem_dina, output, XLEN_W; mem_wea, output, 4; mem_douta, input, XLEN_W: the single-port memory with 1-cycle registered read.

Function
REQ-010 SHALL grant at most one port per cycle; px_req_ready is combinational and is high only for the granted port, in the same cycle as its request.
REQ-011 SHALL treat a request as accepted when px_req_valid and px_req_ready are both high at a rising clk edge; requesters hold the request fields stable until acceptance.
REQ-012 SHALL drive mem_adra, mem_dina and mem_wea combinationally from the granted port; with no grant, mem_wea=0, mem_adra=0 and mem_dina=0.
REQ-013 SHALL assert px_rsp_valid for exactly one cycle, the cycle after acceptance, for both reads and writes; the write response is an acknowledge.
REQ-014 SHALL drive px_rdata=mem_douta when px_rsp_valid is high and the accepted operation was a read; otherwise px_rdata=0.
REQ-015 SHALL record the owner and read flag of each accepted request in a registered response slot, so that back-to-back acceptances on every cycle give full throughput.
REQ-016 SHALL, when only one port requests, grant that port regardless of arbitration state.
REQ-017 SHALL, on contention with fixed priority compiled, grant p0 unless the starvation counter equals STARVE_MAX, in which case it grants p1.
REQ-018 SHALL increment the starvation counter each cycle in which p1 requests and is denied, saturating at STARVE_MAX, and clear it on any p1 grant or whenever p1_req_valid is low.
REQ-019 SHALL keep the write-then-read order to the same address: a read accepted in the cycle after a write returns the written data, because the memory serialises accesses.

Reset
REQ-020 SHALL, while reset_n is low, force both req_ready outputs to 0, both rsp_valid outputs to 0, both rdata outputs to 0, mem_wea to 0, the starvation counter to 0 and the round-robin pointer to p0.
REQ-021 SHALL discard a pending response slot when reset asserts mid-operation; no rsp_valid is issued for it after reset releases.
REQ-022 SHALL accept no request in the first clk edge after reset_n deasserts; arbitration begins on the following edge.

Configuration
REQ-023 SHALL, when DMEM_ARB_RR_EN is defined, arbitrate contention round-robin: the pointer toggles to the other port after each contended grant, and the starvation counter is not implemented.
REQ-024 SHALL, when DMEM_ARB_RR_EN is undefined, use fixed p0 priority with the STARVE_MAX override of REQ-017 and REQ-018.

Structure
REQ-025 SHALL take the widths from the shared defines (`XLEN, `DATA_MEM_ADDR_WIDTH); the port-index constants (PORT_CPU=0, PORT_DMA=1) and the response-slot struct {valid, owner, is_read} SHALL reside in the shared package.
REQ-026 SHALL contain one sub-module, dmem_arb_grant, holding the grant logic, the pointer and the starvation counter; the datapath muxes and response slot stay in the top.

Verification
REQ-027 The bench SHALL apply p0 write addr 0x10, data 0xDEADBEEF, we=4'b1111, then a p0 read of 0x10 the next cycle; it SHALL check for one ack, then p0_rdata=0xDEADBEEF one cycle after the read is accepted.
REQ-028 The bench SHALL apply p0 and p1 both requesting continuously with fixed priority; it SHALL check that p1 is granted exactly on the 5th contended cycle (STARVE_MAX=4) and that the pattern repeats.
REQ-029 The bench SHALL apply the same stimulus with DMEM_ARB_RR_EN defined; it SHALL check that grants alternate p0, p1, p0, p1 with p1_rsp_valid one cycle after each p1 grant.
REQ-030 The bench SHALL apply a byte write we=4'b0010, data 0x0000AB00, to a word holding 0x11223344, then read it back; it SHALL check the readback is 0x1122AB44.
REQ-031 The bench SHALL pull reset_n low in the cycle after a p1 read is accepted; it SHALL check that no p1_rsp_valid appears, all outputs are 0, and the first acceptance occurs on the second edge after release.
REQ-032 The bench SHALL apply p1 alone, requesting on every cycle for 8 reads; it SHALL check 8 acceptances on consecutive edges and 8 consecutive rsp_valid pulses in order.
